// File: rtl/pipelined_bk_adder.sv
// rtl/pipelined_bk_adder.sv - Brent-Kung prefix adder/subtractor with valid/ready pipeline
module pipelined_bk_adder #(
    parameter int WIDTH      = 16,
    parameter bit SIGNED_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L = $clog2(WIDTH);

    // Index 0 is the (g,p) stage; index k holds the result of up-sweep level k.
    logic [L:0][WIDTH-1:0] g_q;
    logic [L:0][WIDTH-1:0] p_q;
    logic [L:0][WIDTH-1:0] pb_q;
    logic [L:0]            v_q;
    logic [L:0]            c0_q;
    logic [L:0]            sub_q;

    logic [L:1][WIDTH-1:0] ug;
    logic [L:1][WIDTH-1:0] up;
    logic [L:1][WIDTH-1:0] dg;

    logic             stall;
    logic [WIDTH-1:0] bb;
    logic             c0;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic             cw;
    logic             ovf_d;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    assign bb   = sub ? ~b : b;
    assign c0   = sub | cin;
    assign p_in = a ^ bb;
    // c0 is folded into bit 0 so every prefix G already includes the carry-in.
    assign g_in = (a & bb) | {{(WIDTH-1){1'b0}}, p_in[0] & c0};

    for (genvar k = 1; k <= L; k++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (1 << k)) == 0) begin : g_op
                assign ug[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-(1<<(k-1))]);
                assign up[k][i] = p_q[k-1][i] & p_q[k-1][i-(1<<(k-1))];
            end else begin : g_pass
                assign ug[k][i] = g_q[k-1][i];
                assign up[k][i] = p_q[k-1][i];
            end
        end
    end

    assign dg[L] = g_q[L];
    // Down-sweep fills the prefixes the up-sweep skipped; P of the right operand is final after up-sweep.
    for (genvar l = 1; l < L; l++) begin : g_down
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i >= (1 << l) + (1 << (l - 1)) - 1) && (((i + 1 + (1 << (l - 1))) % (1 << l)) == 0)) begin : g_op
                assign dg[l][i] = dg[l+1][i] | (p_q[L][i] & dg[l+1][i-(1<<(l-1))]);
            end else begin : g_pass
                assign dg[l][i] = dg[l+1][i];
            end
        end
    end

    assign cw    = dg[1][WIDTH-1];
    assign ovf_d = SIGNED_OVF ? (cw ^ dg[1][WIDTH-2]) : (sub_q[L] ? ~cw : cw);

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            v_q[0]   <= in_valid;
            g_q[0]   <= g_in;
            p_q[0]   <= p_in;
            pb_q[0]  <= p_in;
            c0_q[0]  <= c0;
            sub_q[0] <= sub;
            for (int k = 1; k <= L; k++) begin
                v_q[k]   <= v_q[k-1];
                g_q[k]   <= ug[k];
                p_q[k]   <= up[k];
                pb_q[k]  <= pb_q[k-1];
                c0_q[k]  <= c0_q[k-1];
                sub_q[k] <= sub_q[k-1];
            end
            out_valid <= v_q[L];
            sum       <= pb_q[L] ^ {dg[1][WIDTH-2:0], c0_q[L]};
            cout      <= cw;
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_bk_adder.sv
// tb/tb_pipelined_bk_adder.sv - directed and streamed checks of pipelined_bk_adder at 8/16/64 bits
module tb_pipelined_bk_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic cin = 1'b0;
    logic sub = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [63:0] a64 = '0, b64 = '0;

    logic        in_ready16, out_valid16, cout16, ovf16;
    logic [15:0] sum16;
    logic        in_ready8, out_valid8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        in_ready8u, out_valid8u, cout8u, ovf8u;
    logic [7:0]  sum8u;
    logic        in_ready64, out_valid64, cout64, ovf64;
    logic [63:0] sum64;

    int total = 0;
    int bad = 0;

    logic [15:0] va16 [256];
    logic [15:0] vb16 [256];
    logic [7:0]  va8  [256];
    logic [7:0]  vb8  [256];
    logic        vcin [256];
    logic        vsub [256];
    logic [15:0] rs16 [256];
    logic        rc16 [256];
    logic        ro16 [256];
    logic [7:0]  rs8  [256];
    logic        rc8  [256];
    logic        ro8  [256];
    logic        ro8u [256];
    int nr16, nr8, first8, last8;

    always #5 clk = ~clk;

    pipelined_bk_adder #(.WIDTH(16), .SIGNED_OVF(1'b1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16), .ovf(ovf16));

    pipelined_bk_adder #(.WIDTH(8), .SIGNED_OVF(1'b1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin), .sub(sub),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .ovf(ovf8));

    pipelined_bk_adder #(.WIDTH(8), .SIGNED_OVF(1'b0)) dut8u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8u),
        .a(a8), .b(b8), .cin(cin), .sub(sub),
        .out_valid(out_valid8u), .out_ready(out_ready),
        .sum(sum8u), .cout(cout8u), .ovf(ovf8u));

    pipelined_bk_adder #(.WIDTH(64), .SIGNED_OVF(1'b1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .a(a64), .b(b64), .cin(cin), .sub(sub),
        .out_valid(out_valid64), .out_ready(out_ready),
        .sum(sum64), .cout(cout64), .ovf(ovf64));

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    // Streams vector tables into all instances with out_ready high and records every result.
    task automatic run_stream(input int n);
        int idx = 0;
        int cyc = 0;
        nr16 = 0; nr8 = 0; first8 = -1; last8 = -1;
        out_ready = 1'b1;
        while ((nr16 < n || nr8 < n) && cyc < n + 40) begin
            @(negedge clk);
            if (idx < n) begin
                in_valid = 1'b1;
                a16 = va16[idx]; b16 = vb16[idx];
                a8 = va8[idx]; b8 = vb8[idx];
                cin = vcin[idx]; sub = vsub[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid16 && nr16 < 256) begin
                rs16[nr16] = sum16; rc16[nr16] = cout16; ro16[nr16] = ovf16;
                nr16++;
            end
            if (out_valid8 && nr8 < 256) begin
                rs8[nr8] = sum8; rc8[nr8] = cout8; ro8[nr8] = ovf8; ro8u[nr8] = ovf8u;
                if (first8 < 0) first8 = cyc;
                last8 = cyc;
                nr8++;
            end
            if (in_valid && in_ready16) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst = 1'b1; in_valid = 1'b1;
            a16 = 16'h1234; b16 = 16'h1111; a8 = 8'h12; b8 = 8'h34;
            #1;
            if (c > 0) begin
                total++;
                if (out_valid16 !== 1'b0 || sum16 !== 16'h0 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b want 0/0000/0/0", out_valid16, sum16, cout16, ovf16);
                end
            end
            total++;
            if (in_ready16 !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready: got %b want 1", in_ready16);
            end
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (out_valid16 !== 1'b0 || out_valid8 !== 1'b0) begin
                bad++;
                $display("FAIL reset_ignored_ops: cycle %0d got v16=%b v8=%b want 0", c, out_valid16, out_valid8);
            end
        end
    endtask

    task automatic test_latency;
        int lat16 = -1, lat8 = -1, lat64 = -1;
        logic [15:0] s16; logic c16, o16;
        logic [7:0] s8; logic c8, o8, o8u;
        logic [63:0] s64; logic c64;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        a16 = 16'hFFFF; b16 = 16'h0001;
        a8 = 8'h80; b8 = 8'h80;
        a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) begin
                // the 64-bit case needs cin=1 while the others use 0; set it only for the 64-bit table below
            end
            if (out_valid16 && lat16 < 0) begin lat16 = c; s16 = sum16; c16 = cout16; o16 = ovf16; end
            if (out_valid8 && lat8 < 0) begin lat8 = c; s8 = sum8; c8 = cout8; o8 = ovf8; o8u = ovf8u; end
            if (out_valid64 && lat64 < 0) begin lat64 = c; s64 = sum64; c64 = cout64; end
        end
        total++;
        if (lat16 != 6) begin bad++; $display("FAIL latency16: got %0d want 6", lat16); end
        total++;
        if (lat8 != 5) begin bad++; $display("FAIL latency8: got %0d want 5", lat8); end
        total++;
        if (lat64 != 8) begin bad++; $display("FAIL latency64: got %0d want 8", lat64); end
        total++;
        if (s16 !== 16'h0000 || c16 !== 1'b1 || o16 !== 1'b0) begin
            bad++;
            $display("FAIL ffff_plus_1: got sum=%h c=%b o=%b want 0000/1/0", s16, c16, o16);
        end
        total++;
        if (s8 !== 8'h00 || c8 !== 1'b1 || o8 !== 1'b1 || o8u !== 1'b1) begin
            bad++;
            $display("FAIL 80_plus_80: got sum=%h c=%b o=%b ou=%b want 00/1/1/1", s8, c8, o8, o8u);
        end
        total++;
        if (s64 !== 64'hFFFF_FFFF_FFFF_FFFF || c64 !== 1'b0) begin
            bad++;
            $display("FAIL ones_plus_0_cin0_64: got sum=%h c=%b want ffffffffffffffff/0", s64, c64);
        end
        idle(4);
        // full-length carry chain: all ones + 0 + cin
        @(negedge clk);
        in_valid = 1'b1; cin = 1'b1; sub = 1'b0;
        a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h0;
        @(negedge clk);
        in_valid = 1'b0; cin = 1'b0;
        lat64 = -1;
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            if (out_valid64 && lat64 < 0) begin lat64 = c; s64 = sum64; c64 = cout64; end
        end
        total++;
        if (lat64 != 8 || s64 !== 64'h0 || c64 !== 1'b1) begin
            bad++;
            $display("FAIL carry_chain64: got lat=%0d sum=%h c=%b want 8/0/1", lat64, s64, c64);
        end
        idle(4);
    endtask

    task automatic test_overflow;
        logic [15:0] es [6];
        logic ec [6];
        logic eo [6];
        va16[0] = 16'h7FFF; vb16[0] = 16'h0001; vcin[0] = 0; vsub[0] = 0; es[0] = 16'h8000; ec[0] = 0; eo[0] = 1;
        va16[1] = 16'h8000; vb16[1] = 16'h0001; vcin[1] = 1; vsub[1] = 1; es[1] = 16'h7FFF; ec[1] = 1; eo[1] = 1;
        va16[2] = 16'h0005; vb16[2] = 16'h0005; vcin[2] = 0; vsub[2] = 1; es[2] = 16'h0000; ec[2] = 1; eo[2] = 0;
        va16[3] = 16'h1234; vb16[3] = 16'h4321; vcin[3] = 1; vsub[3] = 0; es[3] = 16'h5556; ec[3] = 0; eo[3] = 0;
        va16[4] = 16'h8000; vb16[4] = 16'h8000; vcin[4] = 0; vsub[4] = 0; es[4] = 16'h0000; ec[4] = 1; eo[4] = 1;
        va16[5] = 16'h0000; vb16[5] = 16'h0001; vcin[5] = 0; vsub[5] = 1; es[5] = 16'hFFFF; ec[5] = 0; eo[5] = 0;
        for (int i = 0; i < 6; i++) begin va8[i] = 8'h0; vb8[i] = 8'h0; end
        run_stream(6);
        total++;
        if (nr16 != 6) begin bad++; $display("FAIL ovf_count: got %0d results want 6", nr16); end
        for (int i = 0; i < 6 && i < nr16; i++) begin
            total++;
            if (rs16[i] !== es[i] || rc16[i] !== ec[i] || ro16[i] !== eo[i]) begin
                bad++;
                $display("FAIL ovf_vec%0d: got sum=%h c=%b o=%b want %h/%b/%b", i, rs16[i], rc16[i], ro16[i], es[i], ec[i], eo[i]);
            end
        end
        idle(8);
    endtask

    task automatic test_back_to_back;
        logic [7:0] bb;
        logic [8:0] full;
        logic ecout, esovf, euovf;
        for (int i = 0; i < 256; i++) begin
            va8[i] = 8'($urandom); vb8[i] = 8'($urandom);
            vcin[i] = 1'($urandom); vsub[i] = 1'($urandom);
            va16[i] = 16'h0; vb16[i] = 16'h0;
        end
        run_stream(256);
        total++;
        if (nr8 != 256) begin bad++; $display("FAIL b2b_count: got %0d results want 256", nr8); end
        total++;
        if (first8 != 5 || last8 - first8 != 255) begin
            bad++;
            $display("FAIL b2b_timing: got first=%0d last=%0d want 5/260", first8, last8);
        end
        for (int i = 0; i < 256 && i < nr8; i++) begin
            bb = vsub[i] ? ~vb8[i] : vb8[i];
            full = {1'b0, va8[i]} + {1'b0, bb} + {8'h0, (vsub[i] ? 1'b1 : vcin[i])};
            ecout = full[8];
            esovf = (va8[i][7] == bb[7]) && (full[7] != va8[i][7]);
            euovf = vsub[i] ? ~ecout : ecout;
            total++;
            if (rs8[i] !== full[7:0] || rc8[i] !== ecout || ro8[i] !== esovf || ro8u[i] !== euovf) begin
                bad++;
                $display("FAIL b2b_op%0d: a=%h b=%h cin=%b sub=%b got %h/%b/%b/%b want %h/%b/%b/%b",
                         i, va8[i], vb8[i], vcin[i], vsub[i], rs8[i], rc8[i], ro8[i], ro8u[i],
                         full[7:0], ecout, esovf, euovf);
            end
        end
        idle(8);
    endtask

    task automatic test_stall;
        int idx = 0;
        int nr = 0;
        int stalls = 0;
        logic held_valid = 1'b0;
        logic [15:0] held = '0;
        logic [15:0] got [12];
        logic [15:0] want;
        for (int c = 0; c < 80 && nr < 12; c++) begin
            @(negedge clk);
            out_ready = !(c >= 8 && c < 18);
            if (idx < 12) begin
                in_valid = 1'b1;
                a16 = 16'(idx * 16'h1111); b16 = 16'h0101; cin = 1'b0; sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid16 && !out_ready) begin
                stalls++;
                total++;
                if (in_ready16 !== 1'b0) begin bad++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", c, in_ready16); end
                if (held_valid) begin
                    total++;
                    if (sum16 !== held) begin bad++; $display("FAIL stall_hold: cycle %0d got %h want %h", c, sum16, held); end
                end
                held = sum16; held_valid = 1'b1;
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid16 && out_ready) begin got[nr] = sum16; nr++; end
            if (in_valid && in_ready16) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (stalls != 10) begin bad++; $display("FAIL stall_cycles: got %0d want 10", stalls); end
        total++;
        if (nr != 12) begin bad++; $display("FAIL stall_count: got %0d results want 12", nr); end
        for (int i = 0; i < 12 && i < nr; i++) begin
            want = 16'(i * 16'h1111 + 16'h0101);
            total++;
            if (got[i] !== want) begin bad++; $display("FAIL stall_order%0d: got %h want %h", i, got[i], want); end
        end
        idle(10);
    endtask

    task automatic test_reset_flush;
        out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            rst = (c == 5);
            in_valid = (c >= 2 && c <= 4);
            a16 = 16'(c * 16'h0100); b16 = 16'h0001; a8 = 8'(c); b8 = 8'h01;
            cin = 1'b0; sub = 1'b0;
            #1;
            if (c == 5) begin
                total++;
                if (in_ready16 !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready16); end
            end
            if (c >= 6) begin
                total++;
                if (out_valid16 !== 1'b0 || out_valid8 !== 1'b0 || out_valid64 !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_stale: cycle %0d got v16=%b v8=%b v64=%b want 0", c, out_valid16, out_valid8, out_valid64);
                end
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
